// File: rtl/booth_r8_pkg.sv
// Shared types and constants for the radix-8 Booth encode front end.
package booth_r8_pkg;

    localparam int WIDTH_DEFAULT = 32;

    // One select bundle per digit group: one-hot magnitude plus negate.
    typedef struct packed {
        logic s;
        logic d;
        logic t;
        logic q;
        logic n;
    } sel_t;

    typedef enum logic [2:0] {
        MAG_0 = 3'd0,
        MAG_1 = 3'd1,
        MAG_2 = 3'd2,
        MAG_3 = 3'd3,
        MAG_4 = 3'd4
    } mag_e;

    localparam sel_t SEL_ZERO = '0;

    function automatic int group_cnt(input int width);
        return (width >> 2) + 3;
    endfunction

endpackage

// File: rtl/booth_r8_digit_enc.sv
// Combinational radix-8 Booth digit encoder: 4-bit window -> {s, d, t, q, n}.
module booth_r8_digit_enc
    import booth_r8_pkg::*;
(
    input  logic [3:0] win,
    output sel_t       sel
);

    mag_e mag;

    // NOTE: every combinational output gets a default before the case so no latch is inferred.
    always_comb begin
        mag = MAG_0;
        case (win)
            4'b0000, 4'b1111: mag = MAG_0;
            4'b0001, 4'b0010,
            4'b1101, 4'b1110: mag = MAG_1;
            4'b0011, 4'b0100,
            4'b1011, 4'b1100: mag = MAG_2;
            4'b0101, 4'b0110,
            4'b1001, 4'b1010: mag = MAG_3;
            4'b0111, 4'b1000: mag = MAG_4;
            default:          mag = MAG_0;
        endcase

        sel   = SEL_ZERO;
        sel.s = (mag == MAG_1);
        sel.d = (mag == MAG_2);
        sel.t = (mag == MAG_3);
        sel.q = (mag == MAG_4);
        // Digit zero is never flagged negative, so 4'b1111 yields all-zero selects.
        sel.n = win[3] && (mag != MAG_0);
    end

endmodule

// File: rtl/booth_r8_encode_stage.sv
// Two-stage valid/ready front end: S1 captures operands, S2 holds Booth selects, my and 3*my.
module booth_r8_encode_stage
    import booth_r8_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEFAULT,
    parameter int GROUP_CNT = group_cnt(WIDTH)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     mx,
    input  logic [WIDTH-1:0]     my,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [GROUP_CNT-1:0] s,
    output logic [GROUP_CNT-1:0] d,
    output logic [GROUP_CNT-1:0] t,
    output logic [GROUP_CNT-1:0] q,
    output logic [GROUP_CNT-1:0] n,
    output logic [WIDTH-1:0]     my_o,
    output logic [WIDTH+1:0]     tmy
);

    localparam int XE_W = 3 * GROUP_CNT + 1;

    logic                 v1_q, v1_d;
    logic [WIDTH-1:0]     mx1_q, mx1_d;
    logic [WIDTH-1:0]     my1_q, my1_d;
    logic                 v2_q, v2_d;
    logic [GROUP_CNT-1:0] s_q, s_d, d_q, d_d, t_q, t_d, q_q, q_d, n_q, n_d;
    logic [WIDTH-1:0]     my_o_q, my_o_d;
    logic [WIDTH+1:0]     tmy_q, tmy_d;

    logic load1, load2;
    logic [XE_W-1:0] xe;
    sel_t enc [GROUP_CNT];

    // x[-1] = 0 at the bottom, zero padding above the MSB keeps the top digit non-negative.
    assign xe = XE_W'({mx1_q, 1'b0});

    for (genvar g = 0; g < GROUP_CNT; g++) begin : g_enc
        booth_r8_digit_enc u_enc (
            .win (xe[3*g +: 4]),
            .sel (enc[g])
        );
    end

    always_comb begin
        load2 = !v2_q || out_ready;
        load1 = !v1_q || load2;

        v1_d   = v1_q;
        mx1_d  = mx1_q;
        my1_d  = my1_q;
        v2_d   = v2_q;
        s_d    = s_q;
        d_d    = d_q;
        t_d    = t_q;
        q_d    = q_q;
        n_d    = n_q;
        my_o_d = my_o_q;
        tmy_d  = tmy_q;

        if (load1) begin
            v1_d = in_valid;
            if (in_valid) begin
                mx1_d = mx;
                my1_d = my;
            end
        end

        if (load2) begin
            v2_d = v1_q;
            if (v1_q) begin
                for (int g = 0; g < GROUP_CNT; g++) begin
                    s_d[g] = enc[g].s;
                    d_d[g] = enc[g].d;
                    t_d[g] = enc[g].t;
                    q_d[g] = enc[g].q;
                    n_d[g] = enc[g].n;
                end
                my_o_d = my1_q;
                tmy_d  = {2'b00, my1_q} + {1'b0, my1_q, 1'b0};
            end
        end
    end

    // NOTE: data registers are reset too because the array input must read zero while reset is held.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            v1_q   <= 1'b0;
            mx1_q  <= '0;
            my1_q  <= '0;
            v2_q   <= 1'b0;
            s_q    <= '0;
            d_q    <= '0;
            t_q    <= '0;
            q_q    <= '0;
            n_q    <= '0;
            my_o_q <= '0;
            tmy_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            v1_q   <= v1_d;
            mx1_q  <= mx1_d;
            my1_q  <= my1_d;
            v2_q   <= v2_d;
            s_q    <= s_d;
            d_q    <= d_d;
            t_q    <= t_d;
            q_q    <= q_d;
            n_q    <= n_d;
            my_o_q <= my_o_d;
            tmy_q  <= tmy_d;
        end
    end

    assign in_ready  = load1;
    assign out_valid = v2_q;
    assign s         = s_q;
    assign d         = d_q;
    assign t         = t_q;
    assign q         = q_q;
    assign n         = n_q;
    assign my_o      = my_o_q;
    assign tmy       = tmy_q;

endmodule

// File: tb/tb_booth_r8_encode_stage.sv
// Scoreboard bench for booth_r8_encode_stage: directed vectors, backpressure, reset, random stream.
`timescale 1ns/1ps
module tb_booth_r8_encode_stage;

    localparam int W = 32;
    localparam int G = 11;

    logic         CLK = 1'b0;
    logic         RST;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] mx, my;
    logic         out_valid;
    logic         out_ready;
    logic [G-1:0] s, d, t, q, n;
    logic [W-1:0] my_o;
    logic [W+1:0] tmy;

    typedef struct {
        logic [W-1:0] mx;
        logic [W-1:0] my;
        logic [G-1:0] s, d, t, q, n;
        logic [W+1:0] tmy;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    bit   rand_ready = 1'b0;

    booth_r8_encode_stage dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mx        (mx),
        .my        (my),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .d         (d),
        .t         (t),
        .q         (q),
        .n         (n),
        .my_o      (my_o),
        .tmy       (tmy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [G-1:0] es, input logic [G-1:0] ed,
                                input logic [G-1:0] et, input logic [G-1:0] eq,
                                input logic [G-1:0] en, input logic [W+1:0] etmy);
        exp_t e;
        e.mx = a; e.my = b;
        e.s = es; e.d = ed; e.t = et; e.q = eq; e.n = en;
        e.tmy = etmy;
        return e;
    endfunction

    // Reference digits straight from the window formula -4*b3 + 2*b2 + b1 + b0.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t         e;
        logic [3*G:0] xe;
        logic [3:0]   w;
        int           dv, mag;
        e.mx = a; e.my = b;
        e.s = '0; e.d = '0; e.t = '0; e.q = '0; e.n = '0;
        xe = {1'b0, a, 1'b0};
        for (int g = 0; g < G; g++) begin
            w   = xe[3*g +: 4];
            dv  = -4 * int'(w[3]) + 2 * int'(w[2]) + int'(w[1]) + int'(w[0]);
            mag = (dv < 0) ? -dv : dv;
            case (mag)
                1: e.s[g] = 1'b1;
                2: e.d[g] = 1'b1;
                3: e.t[g] = 1'b1;
                4: e.q[g] = 1'b1;
                default: ;
            endcase
            e.n[g] = (dv < 0);
        end
        e.tmy = 34'(b) * 34'd3;
        return e;
    endfunction

    // Sum of digit_i * 8^i rebuilt from the selects; must equal mx.
    function automatic longint recon(input logic [G-1:0] rs, input logic [G-1:0] rd,
                                     input logic [G-1:0] rt, input logic [G-1:0] rq,
                                     input logic [G-1:0] rn);
        longint acc = 0;
        longint dig;
        for (int i = G - 1; i >= 0; i--) begin
            dig = rs[i] ? 1 : rd[i] ? 2 : rt[i] ? 3 : rq[i] ? 4 : 0;
            if (rn[i]) dig = -dig;
            acc = acc * 8 + dig;
        end
        return acc;
    endfunction

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
        in_valid = 1'b1;
        mx = a;
        my = b;
        for (int k = 0; k < 1000; k++) begin
            @(negedge CLK);
            if (in_ready) begin
                sb.push_back(e);
                @(posedge CLK);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge CLK);
            #1;
        end
        check("send_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
    endtask

    // Monitor: pops one expectation per output transfer.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (!RST && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("output_without_input", 64'(sb.size()), 64'd1);
                end else begin
                    e = sb.pop_front();
                    check("selects", 64'({s, d, t, q, n}), 64'({e.s, e.d, e.t, e.q, e.n}));
                    check("my_o", 64'(my_o), 64'(e.my));
                    check("tmy", 64'(tmy), 64'(e.tmy));
                    check("recon_mx", 64'(recon(s, d, t, q, n)), 64'(e.mx));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a, b;

        RST = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mx = '0; my = '0;
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_selects", 64'({s, d, t, q, n}), 64'd0);
        check("rst_tmy_my_o", 64'({tmy, my_o}), 64'd0);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // Directed vectors and latency
        send(32'h0000_0007, 32'h5555_5555,
             mk(32'h0000_0007, 32'h5555_5555, 11'h003, 11'h0, 11'h0, 11'h0, 11'h001, 34'h0_FFFF_FFFF));
        check("lat_after_edge0", 64'(out_valid), 64'd0);
        @(posedge CLK);
        #1;
        check("lat_after_edge1", 64'(out_valid), 64'd1);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF,
             mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 11'h001, 11'h0, 11'h0, 11'h400, 11'h001, 34'h2_FFFF_FFFD));
        send(32'h0000_0003, 32'h0000_0001,
             mk(32'h0000_0003, 32'h0000_0001, 11'h0, 11'h0, 11'h001, 11'h0, 11'h0, 34'h3));
        send(32'h0000_0004, 32'h0000_0002,
             mk(32'h0000_0004, 32'h0000_0002, 11'h002, 11'h0, 11'h0, 11'h001, 11'h001, 34'h6));
        send(32'h0000_0000, 32'h0000_0000,
             mk(32'h0000_0000, 32'h0000_0000, 11'h0, 11'h0, 11'h0, 11'h0, 11'h0, 34'h0));
        repeat (4) @(posedge CLK);
        #1;

        // Backpressure: two words fit, the third waits for out_ready
        out_ready = 1'b0;
        send(32'h7, 32'h10, mk(32'h7, 32'h10, 11'h003, 11'h0, 11'h0, 11'h0, 11'h001, 34'h30));
        send(32'h4, 32'h20, mk(32'h4, 32'h20, 11'h002, 11'h0, 11'h0, 11'h001, 11'h001, 34'h60));
        in_valid = 1'b1; mx = 32'h3; my = 32'h30;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_my_o", 64'(my_o), 64'h10);
            check("stall_tmy_sel", 64'({tmy, s, n}), 64'({34'h30, 11'h003, 11'h001}));
            @(posedge CLK);
            #1;
        end
        out_ready = 1'b1;
        @(negedge CLK);
        check("release_in_ready", 64'(in_ready), 64'd1);
        if (in_ready) sb.push_back(mk(32'h3, 32'h30, 11'h0, 11'h0, 11'h001, 11'h0, 11'h0, 34'h90));
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        check("bp_drained", 64'(sb.size()), 64'd0);

        // Reset with both stages full
        out_ready = 1'b0;
        send(32'h7, 32'h1, mk(32'h7, 32'h1, 11'h003, 11'h0, 11'h0, 11'h0, 11'h001, 34'h3));
        send(32'h4, 32'h2, mk(32'h4, 32'h2, 11'h002, 11'h0, 11'h0, 11'h001, 11'h001, 34'h6));
        check("full_before_rst", 64'({out_valid, in_ready}), 64'b10);
        #2;
        RST = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_selects", 64'({s, d, t, q, n}), 64'd0);
        check("midrst_tmy_my_o", 64'({tmy, my_o}), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        sb.delete();
        @(negedge CLK);
        RST = 1'b0;
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        send(32'h3, 32'h5, mk(32'h3, 32'h5, 11'h0, 11'h0, 11'h001, 11'h0, 11'h0, 34'hF));
        check("post_rst_lat0", 64'(out_valid), 64'd0);
        @(posedge CLK);
        #1;
        check("post_rst_lat1", 64'(out_valid), 64'd1);
        repeat (3) @(posedge CLK);
        #1;

        // Random stream with random gaps and backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge CLK);
            #1;
            a = $urandom;
            b = $urandom;
            send(a, b, model(a, b));
        end
        rand_ready = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge CLK);
        @(posedge CLK);
        #1;
        check("final_drained", 64'(sb.size()), 64'd0);
        check("final_idle", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
